kf_sco_unit: RTL and testbench

KF_SCO_UNIT -- requirements
Module: kf_sco_unit

---
 rtl/kf_sco_unit_if.sv | 20 ++
 rtl/kf_sco_unit.sv | 151 +++++++++++++++
 tb/tb_kf_sco_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kf_sco_unit_if.sv
// Output word stream of the KF state/covariance output stage.
interface kf_sco_unit_if #(
  parameter int DATA_W = 64
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_kind;
  logic              m_last;

  modport master (
    output m_valid, m_data, m_kind, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_kind, m_last,
    output m_ready
  );
endinterface

// File: rtl/kf_sco_unit.sv
// KF SCO stage: streams X, then upper-triangular P, then pulses completion.
module kf_sco_unit #(
  parameter  int DATA_W  = 64,
  parameter  int N_STATE = 12,
  localparam int XAW     = $clog2(N_STATE),
  localparam int PAW     = $clog2(N_STATE*N_STATE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_sco,
  input  logic [15:0]       max_iter,
  output logic [XAW-1:0]    x_raddr,
  input  logic [DATA_W-1:0] x_rdata,
  output logic [PAW-1:0]    p_raddr,
  input  logic [DATA_W-1:0] p_rdata,
  kf_sco_unit_if.master     m,
  output logic              SCO_Valid,
  output logic              End_valid,
  output logic [15:0]       iter_cnt,
  output logic              busy
);

  localparam int TOTAL = N_STATE + N_STATE*(N_STATE+1)/2;
  localparam int WCW   = $clog2(TOTAL+1);

  typedef enum logic [1:0] {
    IDLE, STREAM, DONE, WAIT_DROP
  } state_t;

  state_t state_q, state_d;

  logic [WCW-1:0]    widx_q;
  logic [XAW-1:0]    row_q, col_q;
  logic [XAW-1:0]    x_raddr_q;
  logic [PAW-1:0]    p_raddr_q;
  logic              pend_q, pend_kind_q, pend_last_q;
  logic [1:0]        cnt_q, cnt_nxt;
  logic [DATA_W+1:0] e0_q, e1_q, in_w;
  logic [15:0]       iter_q;
  logic              pop, issue, is_x, end_hit;

  assign m.m_valid = cnt_q != 2'd0;
  assign m.m_data  = e0_q[DATA_W-1:0];
  assign m.m_kind  = e0_q[DATA_W];
  assign m.m_last  = m.m_valid & e0_q[DATA_W+1];

  assign pop     = m.m_valid & m.m_ready;
  assign cnt_nxt = cnt_q + {1'b0, pend_q} - {1'b0, pop};
  // A read is issued only if its word is sure to fit in the skid buffer.
  assign issue   = (state_q == STREAM) && (widx_q != WCW'(TOTAL))
                   && (cnt_nxt < 2'd2);
  assign is_x    = widx_q < WCW'(N_STATE);
  assign in_w    = {pend_last_q, pend_kind_q,
                    pend_kind_q ? p_rdata : x_rdata};
  assign end_hit = (max_iter != 16'd0) && (iter_q + 16'd1 == max_iter);

  assign x_raddr  = x_raddr_q;
  assign p_raddr  = p_raddr_q;
  assign iter_cnt = iter_q;
  assign busy     = state_q != IDLE;

  always_comb begin
    state_d   = state_q;
    SCO_Valid = 1'b0;
    End_valid = 1'b0;
    unique case (state_q)
      IDLE:      if (en_sco) state_d = STREAM;
      STREAM:    if (pop && m.m_last) state_d = DONE;
      DONE: begin
        state_d   = WAIT_DROP;
        End_valid = end_hit;
        SCO_Valid = !end_hit;
      end
      WAIT_DROP: if (!en_sco) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DONE) iter_q <= end_hit ? 16'd0 : iter_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      x_raddr_q   <= '0;
      p_raddr_q   <= '0;
      pend_q      <= 1'b0;
      pend_kind_q <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q <= issue;
      if (state_q == IDLE) begin
        widx_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end else if (issue) begin
        widx_q      <= widx_q + WCW'(1);
        pend_kind_q <= !is_x;
        pend_last_q <= widx_q == WCW'(TOTAL-1);
        if (is_x) begin
          x_raddr_q <= XAW'(widx_q);
        end else begin
          p_raddr_q <= PAW'(int'(row_q)*N_STATE + int'(col_q));
          // End of a row: next row starts on its diagonal.
          if (col_q == XAW'(N_STATE-1)) begin
            row_q <= row_q + XAW'(1);
            col_q <= row_q + XAW'(1);
          end else begin
            col_q <= col_q + XAW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      case ({pend_q, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= in_w;
          else               e1_q <= in_w;
        end
        2'b01: e0_q <= e1_q;
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_q <= in_w;
          end else begin
            e0_q <= e1_q;
            e1_q <= in_w;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kf_sco_unit.sv
// Scoreboard bench for kf_sco_unit: frames, stalls, iteration limit, resets.
module tb_kf_sco_unit;

  localparam logic [63:0] XB = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] PB = 64'h5A5A_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_sco;
  logic [15:0] max_iter;
  logic [3:0]  x_raddr;
  logic [7:0]  p_raddr;
  logic [63:0] x_rdata, p_rdata;
  logic        sco_v, end_v;
  logic [15:0] iter_cnt;
  logic        busy;

  int n_vec = 0, n_bad = 0;
  int sco_seen = 0, end_seen = 0, hs_cnt = 0;

  typedef struct packed {
    logic        kind;
    logic        last;
    logic [63:0] data;
  } wd_t;

  wd_t exp_q[$];
  wd_t hd;

  kf_sco_unit_if #(.DATA_W(64)) mif();

  always #5 clk = ~clk;

  // Buffers: each word encodes its own address.
  assign x_rdata = XB | {60'd0, x_raddr};
  assign p_rdata = PB | {56'd0, p_raddr};

  kf_sco_unit #(.DATA_W(64), .N_STATE(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_sco    (en_sco),
    .max_iter  (max_iter),
    .x_raddr   (x_raddr),
    .x_rdata   (x_rdata),
    .p_raddr   (p_raddr),
    .p_rdata   (p_rdata),
    .m         (mif.master),
    .SCO_Valid (sco_v),
    .End_valid (end_v),
    .iter_cnt  (iter_cnt),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic push_frame();
    wd_t w;
    for (int i = 0; i < 12; i++) begin
      w.kind = 1'b0;
      w.last = 1'b0;
      w.data = XB | 64'(i);
      exp_q.push_back(w);
    end
    for (int i = 0; i < 12; i++)
      for (int j = i; j < 12; j++) begin
        w.kind = 1'b1;
        w.last = (i == 11);
        w.data = PB | 64'(i*12 + j);
        exp_q.push_back(w);
      end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mif.m_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected word");
        end else begin
          hd = exp_q[0];
          if (mif.m_ready) begin
            chk("word", {14'd0, mif.m_kind, mif.m_last, mif.m_data},
                {14'd0, hd});
            void'(exp_q.pop_front());
            hs_cnt++;
          end else begin
            chk("stall hold", {14'd0, mif.m_kind, mif.m_last, mif.m_data},
                {14'd0, hd});
          end
        end
      end
      if (sco_v && end_v) fail("both pulses");
      if (sco_v) sco_seen++;
      if (end_v) end_seen++;
    end
  end

  task automatic wait_pulse(input bit rnd, output int cyc, output int fv,
                            output bit ge);
    cyc = 0;
    fv  = -1;
    while (!(sco_v || end_v) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (fv < 0 && mif.m_valid) fv = cyc;
      if (rnd) mif.m_ready = 1'($urandom_range(0, 1));
    end
    mif.m_ready = 1'b1;
    if (!(sco_v || end_v)) fail("pulse timeout");
    ge = end_v;
  endtask

  task automatic run_frame(input bit rnd, input bit hold, output int cyc,
                           output int fv, output bit ge);
    push_frame();
    en_sco = 1'b1;
    wait_pulse(rnd, cyc, fv, ge);
    if (!hold) en_sco = 1'b0;
    @(posedge clk); #1;
    chk("queue drained", exp_q.size(), 0);
    if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cyc, fv, s0, e0, hs0;
    bit ge;
    rst         = 1'b1;
    en_sco      = 1'b0;
    max_iter    = 16'd3;
    mif.m_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst valid", mif.m_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst iter", iter_cnt, 0);
    chk("rst xaddr", x_raddr, 0);
    chk("rst paddr", p_raddr, 0);
    chk("rst last", mif.m_last, 0);
    chk("rst kind", mif.m_kind, 0);
    chk("rst data", mif.m_data, 0);
    chk("rst pulses", {sco_v, end_v}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Three back-to-back frames against max_iter = 3
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 1'b0, cyc, fv, ge);
      chk("frame cycles", cyc, 93);
      chk("first valid", fv, 3);
      chk("end pulse", ge, (f == 2));
      chk("iter_cnt", iter_cnt, (f == 2) ? 0 : f + 1);
    end

    // Random backpressure
    run_frame(1'b1, 1'b0, cyc, fv, ge);
    chk("rnd end pulse", ge, 0);
    chk("rnd iter_cnt", iter_cnt, 1);

    // Ten-cycle stall on the last X word
    push_frame();
    en_sco = 1'b1;
    cyc = 0;
    while (!(mif.m_valid && mif.m_data == (XB | 64'd11)) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    mif.m_ready = 1'b0;
    chk("w11 kind", mif.m_kind, 0);
    chk("w11 data", mif.m_data, XB | 64'd11);
    repeat (10) @(posedge clk); #1;
    chk("w11 held", {mif.m_valid, mif.m_kind, mif.m_data},
        {1'b1, 1'b0, XB | 64'd11});
    mif.m_ready = 1'b1;
    @(posedge clk); #1;
    chk("after stall kind", mif.m_kind, 1);
    chk("after stall data", mif.m_data, PB);
    wait_pulse(1'b0, cyc, fv, ge);
    en_sco = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("stall queue drained", exp_q.size(), 0);
    chk("stall iter_cnt", iter_cnt, 2);

    // Reset in the middle of a frame
    push_frame();
    en_sco = 1'b1;
    s0  = sco_seen + end_seen;
    hs0 = hs_cnt;
    cyc = 0;
    while (hs_cnt - hs0 < 40 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("words before abort", hs_cnt - hs0, 40);
    rst = 1'b1;
    #1;
    chk("abort valid", mif.m_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort iter", iter_cnt, 0);
    exp_q.delete();
    en_sco = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort no pulse", sco_seen + end_seen, s0);
    run_frame(1'b0, 1'b0, cyc, fv, ge);
    chk("post-abort first valid", fv, 3);
    chk("post-abort cycles", cyc, 93);
    chk("post-abort iter", iter_cnt, 1);

    // Unlimited iterations
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    max_iter = 16'd0;
    s0 = sco_seen;
    e0 = end_seen;
    for (int f = 0; f < 5; f++) begin
      run_frame(1'b0, 1'b0, cyc, fv, ge);
      chk("unlim end pulse", ge, 0);
    end
    chk("unlim sco count", sco_seen - s0, 5);
    chk("unlim end count", end_seen - e0, 0);
    chk("unlim iter", iter_cnt, 5);

    // en_sco held high past DONE
    s0 = sco_seen;
    run_frame(1'b0, 1'b1, cyc, fv, ge);
    repeat (20) @(posedge clk); #1;
    chk("hold busy", busy, 1);
    chk("hold valid", mif.m_valid, 0);
    chk("hold one pulse", sco_seen - s0, 1);
    en_sco = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("drop idle", busy, 0);
    run_frame(1'b0, 1'b0, cyc, fv, ge);
    chk("rearm cycles", cyc, 93);
    chk("rearm pulses", sco_seen - s0, 2);
    chk("rearm iter", iter_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
